sensor_slot_decoder: RTL
========================

SENSOR_SLOT_DECODER -- requirements
Module: sensor_slot_decoder

Interface
REQ-001 SHALL have parameter SLOT_W, default 4, meaning sensor address width (2^SLOT_W slots per frame).
REQ-002 SHALL have parameter DATA_W, default 8, meaning sensor sample width (2^DATA_W data steps per frame).
REQ-003 SHALL have port clk_division  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  in  1  request one sampling frame.
REQ-006 SHALL have port slot_bus  in  1  wired-OR of all sensor interface slot outputs.
REQ-007 SHALL have port sample_en  out  1  registered one-cycle pulse broadcast to all sensor interfaces.
REQ-008 SHALL have port busy  out  1  high in every state except IDLE.
REQ-009 SHALL have ports out_valid out 1, out_ready in 1, out_addr out SLOT_W, out_data out DATA_W, out_hit out 1: the drained record stream.
REQ-010 SHALL have port collision  out  1  sticky per-frame flag: an address was hit more than once.
REQ-011 SHALL have port frame_done  out  1  one-cycle pulse after the last record is accepted.

Function
REQ-012 SHALL implement states GUARD, IDLE, ARM, SCAN, DRAIN.
REQ-013 GUARD: 2^(SLOT_W+DATA_W) cycles, then IDLE; start is ignored in GUARD.
REQ-014 IDLE: start=1 -> ARM; sample_en=1 during ARM only.
REQ-015 ARM -> SCAN after exactly one cycle; start in any state other than IDLE is ignored.
REQ-016 SCAN: slot counter (SLOT_W) increments every cycle; data counter (DATA_W) increments when the slot counter wraps from all-ones; both are 0 in the first SCAN cycle, so they match the sensor interface counters cycle-for-cycle.
REQ-017 SCAN: slot_bus=1 with slot counter = a -> record[a].data <= data counter, record[a].hit <= 1.
REQ-018 SCAN ends after the cycle in which both counters are all-ones (2^(SLOT_W+DATA_W) cycles total) -> DRAIN; a hit in that final cycle SHALL be recorded.
REQ-019 DRAIN: presents records in address order 0..2^SLOT_W-1; out_valid=1; out_addr/out_data/out_hit are held stable until out_valid && out_ready.
REQ-020 out_data SHALL be 0 for a record with out_hit=0 (sensor missed).
REQ-021 Acceptance of the last record -> frame_done=1 for one cycle, state IDLE, all hit bits cleared.
REQ-022 collision SHALL clear on entering ARM and stay valid through DRAIN until the next ARM.
REQ-023 out_valid SHALL be 0 outside DRAIN; sample_en SHALL be 0 outside ARM.

Reset
REQ-024 rst_n=0 at any clock edge -> state GUARD, counters 0, guard counter 0, all hit bits 0, sample_en=0, out_valid=0, frame_done=0, collision=0, busy=1.
REQ-025 Reset mid-SCAN or mid-DRAIN SHALL discard the frame; GUARD lets un-reset sensor interfaces finish any in-flight frame.

Configuration
REQ-026 Macro SENSOR_COLLISION_DETECT_EN defined: a hit on an address whose hit bit is already 1 sets collision and keeps the first recorded value.
REQ-027 SENSOR_COLLISION_DETECT_EN undefined: later hit overwrites data, collision tied 0; the port list is unchanged.

Structure
REQ-028 Shared package sensor_ni_pkg SHALL hold the state encoding, the SLOT_W/DATA_W defaults and the frame-length constant.
REQ-029 Sub-module slot_frame_counter SHALL hold the slot/data counter pair (enable, clear, wrap outputs); SCAN and GUARD timing both reuse it.

Verification
REQ-030 Reset, then start held 1 for 4096 cycles -> no sample_en during GUARD; first sample_en exactly one cycle after GUARD exits with start=1.
REQ-031 Modelled sensors addr 3 data 0x5A and addr 15 data 0xFF, out_ready=1 -> 16 records; addr 3 {hit 1, 0x5A}, addr 15 {hit 1, 0xFF}; others {hit 0, 0x00}; frame_done 16 cycles after DRAIN entry.
REQ-032 Sensor addr 0 data 0x00 -> hit in the first SCAN cycle, recorded 0x00 hit 1.
REQ-033 out_ready toggled 1 cycle on / 3 off during DRAIN -> records stay stable while stalled, none lost or duplicated, order 0..15.
REQ-034 Two sensors at addr 7 with data 0x10 and 0x20: with the macro -> collision=1, data 0x10; without -> collision=0, data 0x20.
REQ-035 rst_n pulsed mid-SCAN at cycle 1000 -> outputs take reset values next edge; next frame after GUARD returns clean records.

Source files
------------

// File: rtl/sensor_ni_pkg.sv
// Shared definitions for the sensor slot decoder: FSM encoding, default
// widths and the frame-length constant used by both SCAN and GUARD timing.
package sensor_ni_pkg;

   typedef enum logic [2:0] {
      ST_GUARD = 3'd0,
      ST_IDLE  = 3'd1,
      ST_ARM   = 3'd2,
      ST_SCAN  = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   localparam int SLOT_W_DEF = 4;
   localparam int DATA_W_DEF = 8;

   function automatic int frame_len(input int slot_w, input int data_w);
      return 1 << (slot_w + data_w);
   endfunction

   localparam int FRAME_LEN_DEF = frame_len(SLOT_W_DEF, DATA_W_DEF);

endpackage

// File: rtl/slot_frame_counter.sv
// Slot/data counter pair mirroring the sensor interface counters: slot counts
// every enabled cycle, data steps when slot wraps from all-ones.
module slot_frame_counter #(
   parameter int SLOT_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk_division,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   output logic [SLOT_W-1:0] slot_cnt,
   output logic [DATA_W-1:0] data_cnt,
   output logic              slot_wrap,
   output logic              data_wrap
);

   assign slot_wrap = &slot_cnt;
   assign data_wrap = &data_cnt;

   always_ff @(posedge clk_division) begin
      if (!rst_n || clr) begin
         slot_cnt <= '0;
         data_cnt <= '0;
      end else if (en) begin
         slot_cnt <= slot_cnt + 1'b1;
         if (slot_wrap) begin
            data_cnt <= data_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sensor_slot_decoder.sv
// Frame-based sensor slot decoder: arms sensors, scans the wired-OR slot bus,
// then drains one record per address. Optional macro: SENSOR_COLLISION_DETECT_EN.
module sensor_slot_decoder
   import sensor_ni_pkg::*;
#(
   parameter int SLOT_W = SLOT_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_division,
   input  logic              rst_n,
   input  logic              start,
   input  logic              slot_bus,
   output logic              sample_en,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SLOT_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_hit,
   output logic              collision,
   output logic              frame_done,
   output logic [2:0]        state_dbg
);

   localparam int NSLOT = 1 << SLOT_W;

   state_e              state;
   logic [NSLOT-1:0]    hit_q;
   logic [DATA_W-1:0]   data_q [NSLOT];
   logic [SLOT_W-1:0]   drain_idx;
   logic [SLOT_W-1:0]   slot_cnt;
   logic [DATA_W-1:0]   data_cnt;
   logic                slot_wrap;
   logic                data_wrap;
   logic                frame_end;
   logic                cnt_en;
   logic                cnt_clr;
   logic                rec_write;

   // The same counter pair times GUARD and SCAN; both end on a natural wrap.
   assign cnt_en    = (state == ST_GUARD) || (state == ST_SCAN);
   assign cnt_clr   = (state == ST_IDLE) || (state == ST_ARM);
   assign frame_end = slot_wrap && data_wrap;

   slot_frame_counter #(
      .SLOT_W (SLOT_W),
      .DATA_W (DATA_W)
   ) u_counter (
      .clk_division (clk_division),
      .rst_n        (rst_n),
      .en           (cnt_en),
      .clr          (cnt_clr),
      .slot_cnt     (slot_cnt),
      .data_cnt     (data_cnt),
      .slot_wrap    (slot_wrap),
      .data_wrap    (data_wrap)
   );

`ifdef SENSOR_COLLISION_DETECT_EN
   logic coll_q;
   assign rec_write = (state == ST_SCAN) && slot_bus && !hit_q[slot_cnt];
   assign collision = coll_q;
`else
   assign rec_write = (state == ST_SCAN) && slot_bus;
   assign collision = 1'b0;
`endif

   always_ff @(posedge clk_division) begin
      if (!rst_n) begin
         state      <= ST_GUARD;
         sample_en  <= 1'b0;
         frame_done <= 1'b0;
         hit_q      <= '0;
         drain_idx  <= '0;
`ifdef SENSOR_COLLISION_DETECT_EN
         coll_q     <= 1'b0;
`endif
      end else begin
         sample_en  <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            ST_GUARD: begin
               if (frame_end) begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_ARM;
                  sample_en <= 1'b1;
`ifdef SENSOR_COLLISION_DETECT_EN
                  coll_q    <= 1'b0;
`endif
               end
            end
            ST_ARM: begin
               state <= ST_SCAN;
            end
            ST_SCAN: begin
               if (slot_bus) begin
                  hit_q[slot_cnt] <= 1'b1;
`ifdef SENSOR_COLLISION_DETECT_EN
                  if (hit_q[slot_cnt]) begin
                     coll_q <= 1'b1;
                  end
`endif
               end
               if (frame_end) begin
                  state     <= ST_DRAIN;
                  drain_idx <= '0;
               end
            end
            ST_DRAIN: begin
               if (out_ready) begin
                  if (drain_idx == {SLOT_W{1'b1}}) begin
                     state      <= ST_IDLE;
                     frame_done <= 1'b1;
                     hit_q      <= '0;
                  end else begin
                     drain_idx <= drain_idx + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_GUARD;
            end
         endcase
      end
   end

   // Record data needs no reset: a missed address is masked by its hit bit.
   always_ff @(posedge clk_division) begin
      if (rec_write) begin
         data_q[slot_cnt] <= data_cnt;
      end
   end

   assign busy      = (state != ST_IDLE);
   assign out_valid = (state == ST_DRAIN);
   assign out_addr  = drain_idx;
   assign out_hit   = hit_q[drain_idx];
   assign out_data  = out_hit ? data_q[drain_idx] : '0;
   assign state_dbg = state;

endmodule
